// File: rtl/int_prio_dispatch.sv
// Interrupt priority dispatcher: per-source priority/threshold filtering, a single
// CPU irq line and a claim/complete handshake over an 8-bit slave bus.

module int_prio_dispatch_regs #(
   parameter int N_SRC = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [1:0]  addr,
   input  logic [7:0]  wdata,
   output logic [15:0] prio,
   output logic        en,
   output logic [1:0]  thr
);

   // Priority fields of sources that do not exist stay zero.
   localparam logic [15:0] PRIO_MASK = 16'hFFFF >> (16 - 2 * N_SRC);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prio <= '0;
         en   <= 1'b0;
         thr  <= 2'd0;
      end else if (wr_en) begin
         case (addr)
            2'd0: prio[7:0]  <= wdata & PRIO_MASK[7:0];
            2'd1: prio[15:8] <= wdata & PRIO_MASK[15:8];
            2'd2: begin
               en  <= wdata[7];
               thr <= wdata[1:0];
            end
            default: ;
         endcase
      end
   end

endmodule

// state   | meaning
// IDLE    | no registered winner, irq low
// NOTIFY  | winner registered, irq high, waiting for a CLAIM read
// SERVICE | interrupt claimed, irq held low until matching CLAIM write
module int_prio_dispatch #(
   parameter int N_SRC = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_SRC-1:0] i_pend,
   output logic [N_SRC-1:0] o_clr,
   output logic             o_irq,
   input  logic             i_wb_cyc,
   input  logic [1:0]       i_wb_addr,
   input  logic [7:0]       i_wb_data,
   input  logic             i_wb_we,
   output logic [7:0]       o_wb_rdt,
   output logic             o_wb_ack
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_NOTIFY  = 2'd1,
      ST_SERVICE = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [15:0]      prio;
   logic             en;
   logic [1:0]       thr;
   logic             acc, reg_wr, claim_rd, claim_wr, claim_take;
   logic             best_vld;
   logic [2:0]       best_id;
   logic [1:0]       best_prio, cur_prio;
   logic             win_vld;
   logic [2:0]       win_id;
   logic [2:0]       claim_id;
   logic [N_SRC-1:0] clr_nxt;

   assign acc        = i_wb_cyc & o_wb_ack;
   assign reg_wr     = acc & i_wb_we & (i_wb_addr != 2'd3);
   assign claim_wr   = acc & i_wb_we & (i_wb_addr == 2'd3);
   assign claim_rd   = acc & ~i_wb_we & (i_wb_addr == 2'd3);
   assign claim_take = claim_rd & (state == ST_NOTIFY) & win_vld;

   int_prio_dispatch_regs #(.N_SRC(N_SRC)) u_regs (
      .clk   (clk),
      .rst   (rst),
      .wr_en (reg_wr),
      .addr  (i_wb_addr),
      .wdata (i_wb_data),
      .prio  (prio),
      .en    (en),
      .thr   (thr)
   );

   // Strict '>' keeps the lowest index on equal priority.
   always_comb begin
      best_vld  = 1'b0;
      best_id   = 3'd0;
      best_prio = 2'd0;
      cur_prio  = 2'd0;
      for (int n = 0; n < N_SRC; n++) begin
         cur_prio = prio[2*n +: 2];
         if (i_pend[n] && en && (cur_prio > thr) && (cur_prio > best_prio)) begin
            best_vld  = 1'b1;
            best_id   = 3'(n);
            best_prio = cur_prio;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      clr_nxt   = '0;
      case (state)
         ST_IDLE:
            if (win_vld) state_nxt = ST_NOTIFY;
         ST_NOTIFY:
            if (claim_take) begin
               state_nxt = ST_SERVICE;
               clr_nxt   = N_SRC'(1) << win_id;
            end else if (!win_vld) begin
               state_nxt = ST_IDLE;
            end
         ST_SERVICE:
            if (claim_wr && (i_wb_data[2:0] == claim_id)) state_nxt = ST_IDLE;
         default:
            state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      o_wb_rdt = 8'h00;
      case (i_wb_addr)
         2'd0: o_wb_rdt = prio[7:0];
         2'd1: o_wb_rdt = prio[15:8];
         2'd2: o_wb_rdt = {en, 5'b0, thr};
         2'd3: if (state == ST_NOTIFY && win_vld) o_wb_rdt = {1'b1, 4'b0, win_id};
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         o_irq    <= 1'b0;
         o_clr    <= '0;
         o_wb_ack <= 1'b0;
         win_vld  <= 1'b0;
         win_id   <= 3'd0;
         claim_id <= 3'd0;
      end else begin
         state    <= state_nxt;
         o_irq    <= (state_nxt == ST_NOTIFY);
         o_clr    <= clr_nxt;
         o_wb_ack <= i_wb_cyc & ~o_wb_ack;
         win_vld  <= best_vld;
         win_id   <= best_id;
         if (claim_take) claim_id <= win_id;
      end
   end

endmodule

// File: tb/tb_int_prio_dispatch.sv
// Directed bench for int_prio_dispatch: table of priority/threshold scenarios
// followed by hand-written service, withdrawal and reset sequences.

module tb_int_prio_dispatch;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] i_pend;
   logic [7:0] o_clr;
   logic       o_irq;
   logic       i_wb_cyc;
   logic [1:0] i_wb_addr;
   logic [7:0] i_wb_data;
   logic       i_wb_we;
   logic [7:0] o_wb_rdt;
   logic       o_wb_ack;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic [7:0] lo;
      logic [7:0] hi;
      logic [7:0] ctrl;
      logic [7:0] pend;
      logic [7:0] exp_claim;
   } vec_t;

   vec_t vecs [9];

   int_prio_dispatch #(.N_SRC(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .i_pend    (i_pend),
      .o_clr     (o_clr),
      .o_irq     (o_irq),
      .i_wb_cyc  (i_wb_cyc),
      .i_wb_addr (i_wb_addr),
      .i_wb_data (i_wb_data),
      .i_wb_we   (i_wb_we),
      .o_wb_rdt  (o_wb_rdt),
      .o_wb_ack  (o_wb_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk);
      i_wb_cyc  = 1'b1;
      i_wb_we   = 1'b1;
      i_wb_addr = a;
      i_wb_data = d;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      i_wb_cyc = 1'b0;
      i_wb_we  = 1'b0;
   endtask

   task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
      @(negedge clk);
      i_wb_cyc  = 1'b1;
      i_wb_we   = 1'b0;
      i_wb_addr = a;
      @(posedge clk);
      @(negedge clk);
      d = o_wb_rdt;
      @(posedge clk);
      @(negedge clk);
      i_wb_cyc = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [7:0] rd;
      logic [7:0] one_hot;

      vecs[0] = '{lo: 8'h0C, hi: 8'h00, ctrl: 8'h80, pend: 8'h02, exp_claim: 8'h81};
      vecs[1] = '{lo: 8'h20, hi: 8'h18, ctrl: 8'h80, pend: 8'h64, exp_claim: 8'h82};
      vecs[2] = '{lo: 8'h20, hi: 8'h38, ctrl: 8'h80, pend: 8'h64, exp_claim: 8'h86};
      vecs[3] = '{lo: 8'h80, hi: 8'h00, ctrl: 8'h82, pend: 8'h08, exp_claim: 8'h00};
      vecs[4] = '{lo: 8'h80, hi: 8'h00, ctrl: 8'h81, pend: 8'h08, exp_claim: 8'h83};
      vecs[5] = '{lo: 8'hFF, hi: 8'h00, ctrl: 8'h00, pend: 8'h0F, exp_claim: 8'h00};
      vecs[6] = '{lo: 8'hFF, hi: 8'hFF, ctrl: 8'h80, pend: 8'hF0, exp_claim: 8'h84};
      vecs[7] = '{lo: 8'h00, hi: 8'hC0, ctrl: 8'h80, pend: 8'h81, exp_claim: 8'h87};
      vecs[8] = '{lo: 8'hFF, hi: 8'hFF, ctrl: 8'h80, pend: 8'h00, exp_claim: 8'h00};

      rst       = 1'b1;
      i_pend    = 8'h00;
      i_wb_cyc  = 1'b0;
      i_wb_we   = 1'b0;
      i_wb_addr = 2'd0;
      i_wb_data = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      chk("reset_irq", {7'b0, o_irq}, 8'h00);
      chk("reset_clr", o_clr, 8'h00);
      chk("reset_ack", {7'b0, o_wb_ack}, 8'h00);
      for (int a = 0; a < 4; a++) begin
         bus_rd(2'(a), rd);
         chk($sformatf("reset_reg%0d", a), rd, 8'h00);
      end

      bus_wr(2'd2, 8'h7E);
      bus_rd(2'd2, rd);
      chk("ctrl_readback_mask", rd, 8'h02);

      for (int v = 0; v < 9; v++) begin
         bus_wr(2'd0, vecs[v].lo);
         bus_wr(2'd1, vecs[v].hi);
         bus_wr(2'd2, vecs[v].ctrl);
         bus_rd(2'd2, rd);
         chk($sformatf("v%0d_ctrl_rd", v), rd, vecs[v].ctrl & 8'h83);
         i_pend = vecs[v].pend;
         cycles(2);
         chk($sformatf("v%0d_irq", v), {7'b0, o_irq}, {7'b0, vecs[v].exp_claim[7]});
         bus_rd(2'd3, rd);
         chk($sformatf("v%0d_claim", v), rd, vecs[v].exp_claim);
         if (vecs[v].exp_claim[7]) begin
            one_hot = 8'h01 << vecs[v].exp_claim[2:0];
            chk($sformatf("v%0d_clr", v), o_clr, one_hot);
            chk($sformatf("v%0d_irq_drop", v), {7'b0, o_irq}, 8'h00);
            cycles(1);
            chk($sformatf("v%0d_clr_pulse_end", v), o_clr, 8'h00);
            i_pend = 8'h00;
            bus_wr(2'd3, vecs[v].exp_claim);
         end
         i_pend = 8'h00;
         cycles(2);
         chk($sformatf("v%0d_idle_irq", v), {7'b0, o_irq}, 8'h00);
      end

      // service: mismatching complete is ignored, irq held low
      bus_wr(2'd0, 8'h0C);
      bus_wr(2'd1, 8'h00);
      bus_wr(2'd2, 8'h80);
      i_pend = 8'h02;
      cycles(2);
      chk("svc_irq", {7'b0, o_irq}, 8'h01);
      bus_rd(2'd3, rd);
      chk("svc_claim", rd, 8'h81);
      i_pend = 8'h00;
      bus_wr(2'd3, 8'h04);
      chk("svc_bad_complete_irq", {7'b0, o_irq}, 8'h00);
      i_pend = 8'h02;
      cycles(3);
      chk("svc_hold_irq", {7'b0, o_irq}, 8'h00);
      bus_rd(2'd3, rd);
      chk("svc_claim_in_service", rd, 8'h00);
      bus_wr(2'd3, 8'h01);
      chk("svc_complete_irq_low", {7'b0, o_irq}, 8'h00);
      cycles(1);
      chk("svc_reirq", {7'b0, o_irq}, 8'h01);

      // withdrawal in NOTIFY
      i_pend = 8'h00;
      cycles(1);
      chk("withdraw_irq_1", {7'b0, o_irq}, 8'h01);
      cycles(1);
      chk("withdraw_irq_2", {7'b0, o_irq}, 8'h00);
      bus_rd(2'd3, rd);
      chk("withdraw_claim", rd, 8'h00);

      // reset in the cycle the clear pulse is out
      i_pend = 8'h02;
      cycles(2);
      chk("rst_pre_irq", {7'b0, o_irq}, 8'h01);
      bus_rd(2'd3, rd);
      chk("rst_pre_claim", rd, 8'h81);
      chk("rst_pre_clr", o_clr, 8'h02);
      rst = 1'b1;
      #1;
      chk("rst_irq", {7'b0, o_irq}, 8'h00);
      chk("rst_clr", o_clr, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      cycles(3);
      chk("rst_post_irq", {7'b0, o_irq}, 8'h00);
      bus_rd(2'd0, rd);
      chk("rst_prio_lo", rd, 8'h00);
      bus_rd(2'd2, rd);
      chk("rst_ctrl", rd, 8'h00);
      bus_rd(2'd3, rd);
      chk("rst_claim", rd, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
